// File: rtl/mc_regfile_ctrl.sv
// MCU-facing register file: synchronized async strobes, IDLE/WRITE/READ FSM,
// IO buffer config, PWM on/off with shadowed on-time, and io_din change IRQ.
module mc_regfile_ctrl #(
  parameter int MC_DATA_WIDTH = 16,
  parameter int MC_ADD_WIDTH  = 6,
  parameter int N_IO          = 5
) (
  input  logic                     clock,
  input  logic                     rst_n,
  input  logic                     mc_ce_n,
  input  logic                     mc_we_n,
  input  logic                     mc_oe_n,
  input  logic [MC_ADD_WIDTH-1:0]  mc_add,
  input  logic [MC_DATA_WIDTH-1:0] mc_din,
  output logic [MC_DATA_WIDTH-1:0] mc_dout,
  output logic                     mc_dout_en,
  output logic [N_IO-1:0]          io_oe,
  output logic [N_IO-1:0]          io_od,
  output logic [N_IO-1:0]          io_dir,
  output logic [N_IO-1:0]          io_dout,
  input  logic [N_IO-1:0]          io_din,
  output logic [15:0]              pwm_on,
  output logic [15:0]              pwm_off,
  output logic                     pwm_reset,
  output logic                     irq0_out,
  output logic                     irq0_dir
);
  localparam int DW = MC_DATA_WIDTH;
  localparam int AW = MC_ADD_WIDTH;

  localparam logic [AW-1:0] A_ID   = AW'(0);
  localparam logic [AW-1:0] A_CTRL = AW'(1);
  localparam logic [AW-1:0] A_OE   = AW'(2);
  localparam logic [AW-1:0] A_OD   = AW'(3);
  localparam logic [AW-1:0] A_DIR  = AW'(4);
  localparam logic [AW-1:0] A_DOUT = AW'(5);
  localparam logic [AW-1:0] A_DIN  = AW'(6);
  localparam logic [AW-1:0] A_PON  = AW'(7);
  localparam logic [AW-1:0] A_POFF = AW'(8);
  localparam logic [AW-1:0] A_IRQ  = AW'(9);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  logic [2:0]      strb1_q, strb2_q;
  logic [AW-1:0]   add1_q, add2_q;
  logic [DW-1:0]   din1_q, din2_q;
  logic [N_IO-1:0] io1_q, io2_q, io_prev_q;

  state_t          state_q;
  logic [AW-1:0]   wr_addr_q, rd_addr_q;
  logic [DW-1:0]   wr_data_q, dout_q;
  logic [1:0]      ctrl_q;
  logic [N_IO-1:0] oe_q, od_q, dir_q, iodo_q;
  logic [15:0]     shadow_q, pon_q, poff_q;
  logic            irq_q;

  logic ce_s, we_s, oe_s;
  logic commit, irq_set, irq_clr;

  assign ce_s = strb2_q[2];
  assign we_s = strb2_q[1];
  assign oe_s = strb2_q[0];

  assign commit  = (state_q == WRITE) && (we_s || ce_s);
  assign irq_set = (io2_q != io_prev_q);
  assign irq_clr = commit && (wr_addr_q == A_IRQ) && wr_data_q[0];

  function automatic logic [DW-1:0] rd_mux(input logic [AW-1:0] a);
    logic [DW-1:0] r;
    r = '0;
    unique case (1'b1)
      (a == A_ID):   r = DW'(16'hB0A1);
      (a == A_CTRL): r = DW'(ctrl_q);
      (a == A_OE):   r = DW'(oe_q);
      (a == A_OD):   r = DW'(od_q);
      (a == A_DIR):  r = DW'(dir_q);
      (a == A_DOUT): r = DW'(iodo_q);
      (a == A_DIN):  r = DW'(io2_q);
      (a == A_PON):  r = DW'(shadow_q);
      (a == A_POFF): r = DW'(poff_q);
      (a == A_IRQ):  r = DW'(irq_q);
      default:       r = '0;
    endcase
    return r;
  endfunction

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      strb1_q <= 3'b111;
      strb2_q <= 3'b111;
      add1_q  <= '0;
      add2_q  <= '0;
      din1_q  <= '0;
      din2_q  <= '0;
      io1_q   <= '0;
      io2_q   <= '0;
    end else begin
      strb1_q <= {mc_ce_n, mc_we_n, mc_oe_n};
      strb2_q <= strb1_q;
      add1_q  <= mc_add;
      add2_q  <= add1_q;
      din1_q  <= mc_din;
      din2_q  <= din1_q;
      io1_q   <= io_din;
      io2_q   <= io1_q;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      wr_data_q <= '0;
      dout_q    <= '0;
      ctrl_q    <= '0;
      oe_q      <= '0;
      od_q      <= '0;
      dir_q     <= '0;
      iodo_q    <= '0;
      shadow_q  <= '0;
      pon_q     <= '0;
      poff_q    <= '0;
      irq_q     <= 1'b0;
      io_prev_q <= '0;
    end else begin
      io_prev_q <= io2_q;
      // a change event beats a same-cycle W1C
      if (irq_set)      irq_q <= 1'b1;
      else if (irq_clr) irq_q <= 1'b0;

      unique case (state_q)
        IDLE: begin
          dout_q <= '0;
          if (!ce_s && !we_s) begin
            state_q   <= WRITE;
            wr_addr_q <= add2_q;
            wr_data_q <= din2_q;
          end else if (!ce_s && !oe_s) begin
            state_q   <= READ;
            rd_addr_q <= add2_q;
            dout_q    <= rd_mux(add2_q);
          end
        end
        WRITE: begin
          if (we_s || ce_s) begin
            state_q <= IDLE;
            unique case (1'b1)
              (wr_addr_q == A_CTRL): ctrl_q   <= wr_data_q[1:0];
              (wr_addr_q == A_OE):   oe_q     <= wr_data_q[N_IO-1:0];
              (wr_addr_q == A_OD):   od_q     <= wr_data_q[N_IO-1:0];
              (wr_addr_q == A_DIR):  dir_q    <= wr_data_q[N_IO-1:0];
              (wr_addr_q == A_DOUT): iodo_q   <= wr_data_q[N_IO-1:0];
              (wr_addr_q == A_PON):  shadow_q <= wr_data_q[15:0];
              (wr_addr_q == A_POFF): begin
                poff_q <= wr_data_q[15:0];
                pon_q  <= shadow_q;
              end
              default: ;
            endcase
          end else begin
            wr_addr_q <= add2_q;
            wr_data_q <= din2_q;
          end
        end
        READ: begin
          dout_q <= rd_mux(rd_addr_q);
          if (ce_s || oe_s) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mc_dout    = dout_q;
  assign mc_dout_en = (state_q == READ) && !ce_s && !oe_s;
  assign io_oe      = oe_q;
  assign io_od      = od_q;
  assign io_dir     = dir_q;
  assign io_dout    = iodo_q;
  assign pwm_on     = pon_q;
  assign pwm_off    = poff_q;
  assign pwm_reset  = ~ctrl_q[0];
  assign irq0_dir   = ctrl_q[1];
  assign irq0_out   = ctrl_q[1] & irq_q;

endmodule

// File: tb/tb_mc_regfile_ctrl.sv
// Directed bench for mc_regfile_ctrl: MCU bus writes/reads,
// PWM shadow load, IRQ set/clear race and mid-write reset.
module tb_mc_regfile_ctrl;
  logic        clock = 1'b0;
  logic        rst_n;
  logic        mc_ce_n, mc_we_n, mc_oe_n;
  logic [5:0]  mc_add;
  logic [15:0] mc_din, mc_dout;
  logic        mc_dout_en;
  logic [4:0]  io_oe, io_od, io_dir, io_dout, io_din;
  logic [15:0] pwm_on, pwm_off;
  logic        pwm_reset, irq0_out, irq0_dir;

  int errs = 0;
  int checks = 0;

  always #5 clock = ~clock;

  mc_regfile_ctrl dut (
    .clock(clock), .rst_n(rst_n),
    .mc_ce_n(mc_ce_n), .mc_we_n(mc_we_n), .mc_oe_n(mc_oe_n),
    .mc_add(mc_add), .mc_din(mc_din),
    .mc_dout(mc_dout), .mc_dout_en(mc_dout_en),
    .io_oe(io_oe), .io_od(io_od), .io_dir(io_dir),
    .io_dout(io_dout), .io_din(io_din),
    .pwm_on(pwm_on), .pwm_off(pwm_off), .pwm_reset(pwm_reset),
    .irq0_out(irq0_out), .irq0_dir(irq0_dir)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wr_start(input logic [5:0] a, input logic [15:0] d);
    mc_add  = a;
    mc_din  = d;
    mc_ce_n = 1'b0;
    mc_we_n = 1'b0;
  endtask

  task automatic wr_end();
    mc_we_n = 1'b1;
    mc_ce_n = 1'b1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [15:0] d);
    wr_start(a, d);
    cyc(4);
    wr_end();
    cyc(6);
  endtask

  task automatic rd(input string tag, input logic [5:0] a,
                    input logic [15:0] exp);
    int n;
    mc_add  = a;
    mc_ce_n = 1'b0;
    mc_oe_n = 1'b0;
    cyc(4);
    check({tag, "_en"}, 32'(mc_dout_en), 32'd1);
    check({tag, "_data"}, 32'(mc_dout), 32'(exp));
    mc_oe_n = 1'b1;
    n = 0;
    while (mc_dout_en && n < 3) begin
      cyc(1);
      n++;
    end
    check({tag, "_off"}, 32'(mc_dout_en), 32'd0);
    mc_ce_n = 1'b1;
    cyc(3);
  endtask

  initial begin
    int n, on_c, off_c;
    logic seen;
    rst_n   = 1'b0;
    mc_ce_n = 1'b1;
    mc_we_n = 1'b1;
    mc_oe_n = 1'b1;
    mc_add  = '0;
    mc_din  = '0;
    io_din  = '0;
    cyc(3);
    check("rst_dout", 32'(mc_dout), 32'h0);
    check("rst_dout_en", 32'(mc_dout_en), 32'h0);
    check("rst_io_oe", 32'(io_oe), 32'h0);
    check("rst_pwm_on", 32'(pwm_on), 32'h0);
    check("rst_pwm_off", 32'(pwm_off), 32'h0);
    check("rst_pwm_reset", 32'(pwm_reset), 32'h1);
    check("rst_irq_out", 32'(irq0_out), 32'h0);
    check("rst_irq_dir", 32'(irq0_dir), 32'h0);
    rst_n = 1'b1;
    cyc(2);

    wr_start(6'h02, 16'h001F);
    cyc(4);
    wr_end();
    n = 0;
    while (io_oe != 5'h1F && n < 4) begin
      cyc(1);
      n++;
    end
    check("io_oe_lat", 32'(io_oe), 32'h1F);
    cyc(4);
    rd("rd_oe", 6'h02, 16'h001F);

    wr(6'h07, 16'h0002);
    check("pwm_on_shadow", 32'(pwm_on), 32'h0);
    wr_start(6'h08, 16'h0081);
    cyc(4);
    wr_end();
    on_c = -1;
    off_c = -1;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      if (on_c < 0 && pwm_on == 16'h0002) on_c = i;
      if (off_c < 0 && pwm_off == 16'h0081) off_c = i;
    end
    check("pwm_on_load", 32'(pwm_on), 32'h2);
    check("pwm_off_load", 32'(pwm_off), 32'h81);
    check("pwm_same_cyc", 32'(on_c), 32'(off_c));

    wr(6'h01, 16'hFFF1);
    check("pwm_reset_en", 32'(pwm_reset), 32'h0);
    check("irq_dir_off", 32'(irq0_dir), 32'h0);
    rd("rd_ctrl", 6'h01, 16'h0001);
    rd("rd_id", 6'h00, 16'hB0A1);
    rd("rd_unmapped", 6'h3F, 16'h0000);
    wr(6'h00, 16'h0000);
    rd("rd_id_ro", 6'h00, 16'hB0A1);

    wr(6'h01, 16'h0002);
    check("irq_dir_on", 32'(irq0_dir), 32'h1);
    check("pwm_reset_dis", 32'(pwm_reset), 32'h1);
    check("irq_idle", 32'(irq0_out), 32'h0);
    io_din[4] = 1'b1;
    n = 0;
    while (!irq0_out && n < 4) begin
      cyc(1);
      n++;
    end
    check("irq_set", 32'(irq0_out), 32'h1);
    rd("rd_din", 6'h06, 16'h0010);
    rd("rd_irq", 6'h09, 16'h0001);
    wr_start(6'h09, 16'h0001);
    cyc(4);
    wr_end();
    io_din[4] = 1'b0;
    cyc(6);
    check("irq_set_wins", 32'(irq0_out), 32'h1);
    wr(6'h09, 16'h0001);
    check("irq_w1c", 32'(irq0_out), 32'h0);
    rd("rd_irq_clr", 6'h09, 16'h0000);

    mc_add  = 6'h04;
    mc_din  = 16'h000A;
    mc_ce_n = 1'b0;
    mc_we_n = 1'b0;
    mc_oe_n = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      cyc(1);
      seen |= mc_dout_en;
    end
    mc_ce_n = 1'b1;
    mc_we_n = 1'b1;
    mc_oe_n = 1'b1;
    repeat (6) begin
      cyc(1);
      seen |= mc_dout_en;
    end
    check("we_oe_no_en", 32'(seen), 32'h0);
    check("we_oe_write", 32'(io_dir), 32'h0A);

    wr_start(6'h05, 16'h0015);
    cyc(4);
    rst_n = 1'b0;
    #1;
    check("mid_rst_dir", 32'(io_dir), 32'h0);
    check("mid_rst_oe", 32'(io_oe), 32'h0);
    check("mid_rst_pwm", 32'(pwm_on), 32'h0);
    check("mid_rst_pwmr", 32'(pwm_reset), 32'h1);
    check("mid_rst_irqd", 32'(irq0_dir), 32'h0);
    check("mid_rst_en", 32'(mc_dout_en), 32'h0);
    cyc(2);
    rst_n = 1'b1;
    cyc(3);
    check("no_commit", 32'(io_dout), 32'h0);
    wr_end();
    cyc(6);
    check("new_txn", 32'(io_dout), 32'h15);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/mc_regfile_ctrl.md
MC_REGFILE_CTRL -- requirements
Module: mc_regfile_ctrl

Interface
REQ-001 SHALL take parameter MC_DATA_WIDTH, default 16: width of the memory-controller data bus.
REQ-002 SHALL take parameter MC_ADD_WIDTH, default 6: width of the memory-controller address bus.
REQ-003 SHALL take parameter N_IO, default 5: number of buffered IO channels (MOSI, CLOCK, MISO, CS, AUX).
REQ-004 clock  in  1  single system clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous and active-low.
REQ-006 mc_ce_n, mc_we_n, mc_oe_n  in  1 each  external MCU strobes, asynchronous to clock, active-low.
REQ-007 mc_add  in  MC_ADD_WIDTH  register address; asynchronous.
REQ-008 mc_din  in  MC_DATA_WIDTH  write data from the pad buffer; asynchronous.
REQ-009 mc_dout  out  MC_DATA_WIDTH  read data to the pad buffer.
REQ-010 mc_dout_en  out  1  pad output enable for mc_data.
REQ-011 io_oe, io_od, io_dir, io_dout  out  N_IO each  per-channel IO buffer configuration.
REQ-012 io_din  in  N_IO  pin input values; asynchronous.
REQ-013 pwm_on, pwm_off  out  16 each  PWM on-time and off-time tick counts.
REQ-014 pwm_reset  out  1  PWM reset, active-high.
REQ-015 irq0_out, irq0_dir  out  1 each  interrupt level and pin output enable.

Function
REQ-016 Every asynchronous input SHALL pass through a 2-flop synchronizer; all logic SHALL use only synchronized copies.
REQ-017 Register map (word address): 0x00 ID RO 0xB0A1; 0x01 CTRL (bit0 pwm_en, bit1 irq_en); 0x02 IO_OE; 0x03 IO_OD; 0x04 IO_DIR; 0x05 IO_DOUT; 0x06 IO_DIN RO; 0x07 PWM_ON shadow; 0x08 PWM_OFF; 0x09 IRQ_STAT W1C (bit0 = io_din changed).
REQ-018 Unmapped addresses SHALL read 0; writes to them and to RO registers SHALL be ignored; unused upper bits SHALL read 0.
REQ-019 The FSM SHALL have states IDLE, WRITE, READ.
REQ-020 IDLE->WRITE when synced ce_n=0 and we_n=0; this SHALL take priority over a simultaneous read request.
REQ-021 In WRITE, address and data SHALL be re-captured every cycle; the commit SHALL occur on the first cycle with synced we_n=1 or ce_n=1, then return to IDLE.
REQ-022 A committed write SHALL be visible on outputs 1 cycle after the commit cycle.
REQ-023 IDLE->READ when synced ce_n=0, oe_n=0 and we_n=1; the address SHALL latch on entry.
REQ-024 mc_dout SHALL be valid and mc_dout_en=1 from the cycle after READ entry.
REQ-025 READ SHALL exit to IDLE on synced ce_n=1 or oe_n=1; mc_dout_en SHALL be 0 in that same cycle (combinational from state and synced strobes).
REQ-026 mc_dout_en SHALL never be 1 outside READ; a we_n assertion during READ SHALL be ignored until return to IDLE.
REQ-027 A write to PWM_ON SHALL update only the shadow register; a write to PWM_OFF SHALL load pwm_off and copy the shadow into pwm_on in the same cycle.
REQ-028 pwm_reset SHALL equal NOT CTRL.pwm_en.
REQ-029 IRQ_STAT.bit0 SHALL set when synced io_din differs from its value one cycle earlier.
REQ-030 If a set event and a W1C clear occur in the same cycle, the set SHALL win.
REQ-031 irq0_dir SHALL equal CTRL.irq_en; irq0_out SHALL equal CTRL.irq_en AND IRQ_STAT.bit0.

Reset
REQ-032 rst_n=0 SHALL immediately force: FSM to IDLE, mc_dout=0, mc_dout_en=0, all io_* outputs 0, pwm_on=pwm_off=shadow=0, pwm_reset=1, IRQ_STAT=0, irq0_out=0, irq0_dir=0, and all synchronizer flops to their idle level (strobes=1, data=0).
REQ-033 Reset asserted mid-transaction SHALL abort that transaction with no commit; after release, a strobe still held low SHALL be treated as a new transaction.

Verification
REQ-034 Write 0x001F to 0x02 (we_n low for 4 clocks) -> io_oe=5'b11111 within 4 clocks of we_n rising; a read of 0x02 returns 0x001F.
REQ-035 Write PWM_ON=0x0002 -> pwm_on unchanged; then write PWM_OFF=0x0081 -> pwm_on=0x0002 and pwm_off=0x0081 change in the same cycle; write CTRL=0x0001 -> pwm_reset=0.
REQ-036 Read 0x00 -> mc_dout_en=1 with mc_dout=0xB0A1; raise oe_n -> mc_dout_en=0 within 3 clocks; read 0x3F -> 0x0000.
REQ-037 With CTRL=0x0002, toggle io_din[4] -> irq0_out=1 within 4 clocks; W1C 0x0001 to 0x09 in the same cycle as another toggle -> bit0 stays 1.
REQ-038 Assert we_n and oe_n together -> write performed, mc_dout_en stays 0; assert rst_n=0 mid-write -> no register change, all outputs at their reset values.
